// File: rtl/sha256_share_arbiter.sv
// Round-robin, transaction-locked arbiter that shares one SHA-256 core between NUM_PORTS requesters.
// Forwards only the owner's commands, routes the digest back to the owner and aborts stalled owners.
module sha256_share_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_PORTS-1:0]    req_i,
    output logic [NUM_PORTS-1:0]    grant_o,
    input  logic [NUM_PORTS-1:0]    start_i,
    input  logic [NUM_PORTS-1:0]    update_i,
    input  logic [NUM_PORTS-1:0]    finalize_i,
    input  logic [32*NUM_PORTS-1:0] data_i,
    input  logic [3*NUM_PORTS-1:0]  bytes_valid_i,
    output logic [NUM_PORTS-1:0]    hash_valid_o,
    output logic [255:0]            hash_o,
    output logic                    err_drop_o,
    output logic                    timeout_o,
    output logic                    sha_start,
    output logic                    sha_update,
    output logic [31:0]             sha_data_in,
    output logic [2:0]              sha_bytes_valid,
    output logic                    sha_finalize,
    input  logic                    sha_hash_valid,
    input  logic [255:0]            sha_hash
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {IDLE, GRANTED, ACTIVE, WAIT_HASH, ABORT} state_t;

    state_t        state_reg;
    logic [PW-1:0] owner_reg;
    logic [PW-1:0] rr_ptr_reg;
    logic [CW-1:0] idle_cnt_reg;

    logic [NUM_PORTS-1:0] owner_onehot;
    logic [NUM_PORTS-1:0] pick_onehot;
    logic [NUM_PORTS-1:0] cmd_any;
    logic                 own_req, own_start, own_update, own_finalize, own_cmd;
    logic [31:0]          own_data;
    logic [2:0]           own_bytes;
    logic                 fwd, fwd_cmd, err_drop, timeout_hit;
    logic                 found;
    logic [PW-1:0]        pick, rr_next;

    assign own_req      = req_i[owner_reg];
    assign own_start    = start_i[owner_reg];
    assign own_update   = update_i[owner_reg];
    assign own_finalize = finalize_i[owner_reg];
    assign own_data     = data_i[int'(owner_reg)*32 +: 32];
    assign own_bytes    = bytes_valid_i[int'(owner_reg)*3 +: 3];
    assign own_cmd      = own_start | own_update | own_finalize;
    assign cmd_any      = start_i | update_i | finalize_i;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_dec
            assign owner_onehot[gi] = (owner_reg == PW'(gi));
            assign pick_onehot[gi]  = (pick == PW'(gi));
        end
    endgenerate

    // A finalize from an owner that is simultaneously dropping req_i still counts as a normal finalize.
    assign fwd = ((state_reg == GRANTED) && own_req) ||
                 ((state_reg == ACTIVE) && (own_req || own_finalize));
    assign fwd_cmd  = fwd && own_cmd;
    assign err_drop = (|(cmd_any & ~owner_onehot)) | (own_cmd & ~fwd);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && own_req && !own_cmd &&
                         (idle_cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(rr_ptr_reg) + i) % NUM_PORTS;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    assign rr_next = (pick == PW'(NUM_PORTS - 1)) ? '0 : pick + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            owner_reg       <= '0;
            rr_ptr_reg      <= '0;
            idle_cnt_reg    <= '0;
            grant_o         <= '0;
            hash_valid_o    <= '0;
            hash_o          <= '0;
            err_drop_o      <= 1'b0;
            timeout_o       <= 1'b0;
            sha_start       <= 1'b0;
            sha_update      <= 1'b0;
            sha_finalize    <= 1'b0;
            sha_data_in     <= '0;
            sha_bytes_valid <= '0;
        end else begin
            sha_start    <= 1'b0;
            sha_update   <= 1'b0;
            sha_finalize <= 1'b0;
            hash_valid_o <= '0;
            timeout_o    <= 1'b0;
            err_drop_o   <= err_drop;
            if (fwd_cmd) begin
                sha_start       <= own_start;
                sha_update      <= own_update;
                sha_finalize    <= own_finalize;
                sha_data_in     <= own_data;
                sha_bytes_valid <= own_bytes;
            end
            case (state_reg)
                IDLE: begin
                    if (found) begin
                        owner_reg    <= pick;
                        rr_ptr_reg   <= rr_next;
                        grant_o      <= pick_onehot;
                        idle_cnt_reg <= '0;
                        state_reg    <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (!own_req) begin
                        grant_o   <= '0;
                        state_reg <= IDLE;
                    end else if (own_start) begin
                        idle_cnt_reg <= '0;
                        state_reg    <= ACTIVE;
                    end else if (timeout_hit) begin
                        timeout_o <= 1'b1;
                        grant_o   <= '0;
                        state_reg <= IDLE;
                    end else if (own_cmd) begin
                        idle_cnt_reg <= '0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (own_finalize) begin
                        state_reg <= WAIT_HASH;
                    end else if (!own_req || timeout_hit) begin
                        // Close the core's transaction ourselves so the digest can be drained.
                        sha_finalize <= 1'b1;
                        timeout_o    <= own_req;
                        grant_o      <= '0;
                        state_reg    <= ABORT;
                    end else if (own_cmd) begin
                        idle_cnt_reg <= '0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end
                end
                WAIT_HASH: begin
                    if (sha_hash_valid) begin
                        hash_valid_o <= owner_onehot;
                        hash_o       <= sha_hash;
                        grant_o      <= '0;
                        state_reg    <= IDLE;
                    end
                end
                ABORT: begin
                    if (sha_hash_valid) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_share_arbiter.sv
// Directed bench for sha256_share_arbiter: the bench plays the SHA core and scoreboards
// forwarded core commands and delivered digests against queued expectations.
module tb_sha256_share_arbiter;
    localparam int NP = 2;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NP-1:0]  req_i = '0, start_i = '0, update_i = '0, finalize_i = '0;
    logic [32*NP-1:0] data_i = '0;
    logic [3*NP-1:0]  bytes_valid_i = '0;
    logic [NP-1:0]  grant_o, hash_valid_o;
    logic [255:0]   hash_o;
    logic           err_drop_o, timeout_o;
    logic           sha_start, sha_update, sha_finalize;
    logic [31:0]    sha_data_in;
    logic [2:0]     sha_bytes_valid;
    logic           sha_hash_valid = 1'b0;
    logic [255:0]   sha_hash = '0;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [2:0] p; logic [31:0] d; logic [2:0] b; } cmd_t;
    typedef struct { logic [NP-1:0] hv; logic [255:0] h; } dig_t;
    cmd_t cmd_q[$];
    dig_t dig_q[$];

    sha256_share_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .grant_o(grant_o),
        .start_i(start_i), .update_i(update_i), .finalize_i(finalize_i),
        .data_i(data_i), .bytes_valid_i(bytes_valid_i),
        .hash_valid_o(hash_valid_o), .hash_o(hash_o),
        .err_drop_o(err_drop_o), .timeout_o(timeout_o),
        .sha_start(sha_start), .sha_update(sha_update), .sha_data_in(sha_data_in),
        .sha_bytes_valid(sha_bytes_valid), .sha_finalize(sha_finalize),
        .sha_hash_valid(sha_hash_valid), .sha_hash(sha_hash)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle command pulse; fwd says whether the arbiter should pass it to the core.
    task automatic cmd(input int p, input logic s, input logic u, input logic f,
                       input logic [31:0] d, input logic [2:0] b, input bit fwd);
        cmd_t e;
        start_i[p] = s; update_i[p] = u; finalize_i[p] = f;
        data_i[p*32 +: 32] = d; bytes_valid_i[p*3 +: 3] = b;
        if (fwd) begin
            e.p = {s, u, f}; e.d = d; e.b = b;
            cmd_q.push_back(e);
        end
        tick();
        start_i = '0; update_i = '0; finalize_i = '0;
        chk("cmd_latency", 256'({sha_start, sha_update, sha_finalize}), fwd ? 256'({s, u, f}) : 256'(0));
        chk("cmd_drop", 256'(err_drop_o), 256'(!fwd));
    endtask

    task automatic digest(input logic [255:0] h, input logic [NP-1:0] exp_hv);
        dig_t e;
        sha_hash_valid = 1'b1; sha_hash = h;
        if (exp_hv != '0) begin
            e.hv = exp_hv; e.h = h;
            dig_q.push_back(e);
        end
        tick();
        sha_hash_valid = 1'b0;
        chk("digest_hv", 256'(hash_valid_o), 256'(exp_hv));
        chk("digest_grant_clear", 256'(grant_o), 256'(0));
    endtask

    task automatic push_auto_finalize();
        cmd_t e;
        e.p = 3'b001; e.d = '0; e.b = '0;
        cmd_q.push_back(e);
    endtask

    // Scoreboard monitor: every core command and every digest strobe must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sha_start || sha_update || sha_finalize) begin
                chk("mon_cmd_expected", 256'(cmd_q.size() != 0), 256'(1));
                if (cmd_q.size() != 0) begin
                    cmd_t e;
                    e = cmd_q.pop_front();
                    chk("mon_cmd_pulses", 256'({sha_start, sha_update, sha_finalize}), 256'(e.p));
                    if (e.p[1]) begin
                        chk("mon_cmd_data", 256'(sha_data_in), 256'(e.d));
                        chk("mon_cmd_bytes", 256'(sha_bytes_valid), 256'(e.b));
                    end
                end
            end
            if (hash_valid_o != '0) begin
                chk("mon_dig_expected", 256'(dig_q.size() != 0), 256'(1));
                if (dig_q.size() != 0) begin
                    dig_t e;
                    e = dig_q.pop_front();
                    chk("mon_dig_hv", 256'(hash_valid_o), 256'(e.hv));
                    chk("mon_dig_hash", hash_o, e.h);
                end
            end
        end
    end

    initial begin
        int n;
        // Reset state
        tick(); tick();
        chk("rst_grant", 256'(grant_o), 256'(0));
        chk("rst_hv", 256'(hash_valid_o), 256'(0));
        chk("rst_hash", hash_o, 256'(0));
        chk("rst_flags", 256'({err_drop_o, timeout_o}), 256'(0));
        chk("rst_sha", 256'({sha_start, sha_update, sha_finalize, sha_data_in, sha_bytes_valid}), 256'(0));
        rst_n = 1'b1;

        // Single-port transaction
        req_i = 2'b01;
        tick();
        chk("t1_grant", 256'(grant_o), 256'(2'b01));
        cmd(0, 1, 0, 0, 32'h0, 3'd0, 1);
        cmd(0, 0, 1, 0, 32'hDEADBEEF, 3'd4, 1);
        cmd(0, 0, 1, 0, 32'h01234567, 3'd4, 1);
        cmd(0, 0, 0, 1, 32'h0, 3'd0, 1);
        tick(); tick();
        digest({8{32'hA5A5_0001}}, 2'b01);
        req_i = 2'b00;
        tick();

        // Simultaneous requests from reset, plus a dropped non-owner command
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req_i = 2'b11;
        tick();
        chk("t2_grant_p0", 256'(grant_o), 256'(2'b01));
        cmd(1, 0, 1, 0, 32'h1111_2222, 3'd4, 0);
        tick();
        chk("t3_drop_one_cycle", 256'(err_drop_o), 256'(0));
        cmd(0, 1, 0, 0, 32'h0, 3'd0, 1);
        cmd(0, 0, 0, 1, 32'h0, 3'd0, 1);
        digest({8{32'hB00B_0002}}, 2'b01);
        tick();
        chk("t2_grant_p1", 256'(grant_o), 256'(2'b10));
        cmd(1, 1, 0, 0, 32'h0, 3'd0, 1);
        cmd(1, 0, 1, 0, 32'hAABBCCDD, 3'd2, 1);
        cmd(1, 0, 0, 1, 32'h0, 3'd0, 1);
        digest({8{32'hC0DE_0003}}, 2'b10);
        tick();
        chk("t2_grant_p0_again", 256'(grant_o), 256'(2'b01));
        // Owner withdraws in GRANTED
        req_i = 2'b00;
        tick();
        chk("t2_withdraw_grant", 256'(grant_o), 256'(0));

        // Owner abandons after one update: arbiter finalizes, digest discarded
        req_i = 2'b01;
        tick();
        chk("t4_grant", 256'(grant_o), 256'(2'b01));
        cmd(0, 1, 0, 0, 32'h0, 3'd0, 1);
        cmd(0, 0, 1, 0, 32'h55AA55AA, 3'd3, 1);
        push_auto_finalize();
        req_i = 2'b00;
        tick();
        chk("t4_auto_finalize", 256'(sha_finalize), 256'(1));
        chk("t4_grant_clear", 256'(grant_o), 256'(0));
        digest({8{32'hDEAD_0004}}, 2'b00);
        req_i = 2'b10;
        tick();
        chk("t4_back_to_idle", 256'(grant_o), 256'(2'b10));

        // Idle timeout in ACTIVE
        cmd(1, 1, 0, 0, 32'h0, 3'd0, 1);
        push_auto_finalize();
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (timeout_o) begin
                n = i;
                break;
            end
        end
        req_i = 2'b00;
        chk("t5_timeout_seen", 256'(n != 0), 256'(1));
        chk("t5_timeout_window", 256'(n >= TO && n <= TO + 1), 256'(1));
        chk("t5_timeout_finalize", 256'(sha_finalize), 256'(1));
        chk("t5_timeout_grant", 256'(grant_o), 256'(0));
        tick();
        chk("t5_timeout_pulse", 256'(timeout_o), 256'(0));
        digest({8{32'hFEED_0005}}, 2'b00);

        // Reset while waiting for the digest
        req_i = 2'b01;
        tick();
        chk("t6_grant", 256'(grant_o), 256'(2'b01));
        cmd(0, 1, 0, 0, 32'h0, 3'd0, 1);
        cmd(0, 0, 0, 1, 32'h0, 3'd0, 1);
        cmd(0, 0, 1, 0, 32'h7777_8888, 3'd1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_grant", 256'(grant_o), 256'(0));
        chk("t6_async_flags", 256'({err_drop_o, timeout_o, hash_valid_o}), 256'(0));
        chk("t6_async_sha", 256'({sha_start, sha_update, sha_finalize, sha_data_in}), 256'(0));
        tick();
        rst_n = 1'b1;
        req_i = 2'b10;
        tick();
        chk("t6_regrant", 256'(grant_o), 256'(2'b10));

        // Finalize in the same cycle the owner drops req_i: digest still delivered
        cmd(1, 1, 0, 0, 32'h0, 3'd0, 1);
        req_i = 2'b00;
        cmd(1, 0, 0, 1, 32'h0, 3'd0, 1);
        chk("t7_grant_held", 256'(grant_o), 256'(2'b10));
        tick();
        digest({8{32'h600D_0006}}, 2'b10);
        tick(); tick();

        chk("cmd_q_empty", 256'(cmd_q.size()), 256'(0));
        chk("dig_q_empty", 256'(dig_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
